// File: rtl/matrix_mac_engine_if.sv
// Host-side bus of the matrix MAC engine: job control, status flags and shared RAM access.
interface matrix_mac_engine_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] memory_address;
   logic [DATA_WIDTH-1:0] memory_data_in;
   logic                  write_enable;
   logic [DATA_WIDTH-1:0] memory_data_out;
   logic                  busy;
   logic                  result_ready;
   logic                  error;

   modport master (
      output start, memory_address, memory_data_in, write_enable,
      input  memory_data_out, busy, result_ready, error
   );

   modport slave (
      input  start, memory_address, memory_data_in, write_enable,
      output memory_data_out, busy, result_ready, error
   );
endinterface

// File: rtl/matrix_mac_engine.sv
// Signed rectangular C = A x B engine over an internal dual-port RAM.
// Host owns RAM port b while idle; the engine reads A/writes C on port a and reads B on port b.
module matrix_mac_engine #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 12,
   parameter int MAX_LEN     = 100,
   parameter int MAX_LEN_LOG = 7,
   parameter int ACC_WIDTH   = 64,
   parameter int SATURATE    = 0
) (
   input logic                clk,
   input logic                reset,
   matrix_mac_engine_if.slave host
);
   localparam int PW = 2 * DATA_WIDTH;
   localparam int CW = MAX_LEN_LOG + 1;
   localparam logic [31:0]                  DEPTH    = 32'(2 ** ADDR_WIDTH);
   localparam logic [DATA_WIDTH-1:0]        MAX_DIM  = DATA_WIDTH'(MAX_LEN);
   localparam logic [MAX_LEN_LOG-1:0]       IDX_ONE  = MAX_LEN_LOG'(1);
   localparam logic [ADDR_WIDTH-1:0]        ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [CW-1:0]                PH_ONE   = CW'(1);
   localparam logic signed [ACC_WIDTH-1:0]  SAT_MAX  =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0]  SAT_MIN  = ~SAT_MAX;

   typedef enum logic [2:0] {IDLE, HDR, CHECK, RUN, DONE} state_t;

   state_t                  state;
   logic                    busy, result_ready, error;
   logic [1:0]              hdr_cnt;
   logic [DATA_WIDTH-1:0]   m_word, k_word, n_word;
   logic [MAX_LEN_LOG-1:0]  m_len, k_len, n_len, i_idx, j_idx;
   logic [CW-1:0]           phase, last_phase;
   logic [ADDR_WIDTH-1:0]   a_ptr, row_base, b_ptr, b_col, b_base, c_ptr;
   logic [31:0]             mk, kn, mn, end_addr;
   logic                    dims_bad;

   logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0]   addr_a, addr_b;
   logic                    we_a, we_b;
   logic [DATA_WIDTH-1:0]   wdata_a, wdata_b, rdata_a, rdata_b;

   logic                    v1, f1, v2, f2;
   logic signed [PW-1:0]    prod;
   logic signed [ACC_WIDTH-1:0] prod_ext, acc;
   logic [DATA_WIDTH-1:0]   c_value;

   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= wdata_a;
      if (we_b) mem[addr_b] <= wdata_b;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else begin
         rdata_a <= mem[addr_a];
         rdata_b <= mem[addr_b];
      end
   end

   always_comb begin
      mk         = 32'(m_word[MAX_LEN_LOG-1:0]) * 32'(k_word[MAX_LEN_LOG-1:0]);
      kn         = 32'(k_word[MAX_LEN_LOG-1:0]) * 32'(n_word[MAX_LEN_LOG-1:0]);
      mn         = 32'(m_word[MAX_LEN_LOG-1:0]) * 32'(n_word[MAX_LEN_LOG-1:0]);
      end_addr   = 32'd3 + mk + kn + mn;
      dims_bad   = (m_word == '0) || (m_word > MAX_DIM) ||
                   (k_word == '0) || (k_word > MAX_DIM) ||
                   (n_word == '0) || (n_word > MAX_DIM);
      last_phase = CW'(k_len) + CW'(2);
   end

   always_comb begin
      addr_a  = a_ptr;
      we_a    = 1'b0;
      wdata_a = c_value;
      if (state == HDR) begin
         addr_a = ADDR_WIDTH'(hdr_cnt);
      end else if (state == RUN && phase == last_phase) begin
         addr_a = c_ptr;
         we_a   = 1'b1;
      end
      addr_b  = busy ? b_ptr : host.memory_address;
      we_b    = !busy && host.write_enable;
      wdata_b = host.memory_data_in;
   end

   assign host.memory_data_out = busy ? '0 : rdata_b;
   assign host.busy            = busy;
   assign host.result_ready    = result_ready;
   assign host.error           = error;

   // One element per K+3 cycles: K issue cycles, then product stage, accumulate stage, C write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         busy         <= 1'b0;
         result_ready <= 1'b0;
         error        <= 1'b0;
         hdr_cnt      <= '0;
         m_word       <= '0;
         k_word       <= '0;
         n_word       <= '0;
         m_len        <= '0;
         k_len        <= '0;
         n_len        <= '0;
         i_idx        <= '0;
         j_idx        <= '0;
         phase        <= '0;
         a_ptr        <= '0;
         row_base     <= '0;
         b_ptr        <= '0;
         b_col        <= '0;
         b_base       <= '0;
         c_ptr        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (host.start) begin
                  state        <= HDR;
                  busy         <= 1'b1;
                  result_ready <= 1'b0;
                  error        <= 1'b0;
                  hdr_cnt      <= '0;
               end
            end
            HDR: begin
               hdr_cnt <= hdr_cnt + 2'd1;
               case (hdr_cnt)
                  2'd1: m_word <= rdata_a;
                  2'd2: k_word <= rdata_a;
                  2'd3: begin
                     n_word <= rdata_a;
                     state  <= CHECK;
                  end
                  default: ;
               endcase
            end
            CHECK: begin
               if (dims_bad || end_addr > DEPTH) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  error <= 1'b1;
               end else begin
                  state    <= RUN;
                  m_len    <= m_word[MAX_LEN_LOG-1:0];
                  k_len    <= k_word[MAX_LEN_LOG-1:0];
                  n_len    <= n_word[MAX_LEN_LOG-1:0];
                  i_idx    <= '0;
                  j_idx    <= '0;
                  phase    <= '0;
                  a_ptr    <= ADDR_WIDTH'(3);
                  row_base <= ADDR_WIDTH'(3);
                  b_base   <= ADDR_WIDTH'(32'd3 + mk);
                  b_col    <= ADDR_WIDTH'(32'd3 + mk);
                  b_ptr    <= ADDR_WIDTH'(32'd3 + mk);
                  c_ptr    <= ADDR_WIDTH'(32'd3 + mk + kn);
               end
            end
            RUN: begin
               if (phase < CW'(k_len)) begin
                  a_ptr <= a_ptr + ADDR_ONE;
                  b_ptr <= b_ptr + ADDR_WIDTH'(n_len);
               end
               if (phase == last_phase) begin
                  phase <= '0;
                  c_ptr <= c_ptr + ADDR_ONE;
                  if (j_idx == n_len - IDX_ONE) begin
                     // a_ptr already sits at the next row start after K increments
                     j_idx    <= '0;
                     row_base <= a_ptr;
                     b_col    <= b_base;
                     b_ptr    <= b_base;
                     if (i_idx == m_len - IDX_ONE) begin
                        i_idx        <= '0;
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_ready <= 1'b1;
                     end else begin
                        i_idx <= i_idx + IDX_ONE;
                     end
                  end else begin
                     j_idx <= j_idx + IDX_ONE;
                     a_ptr <= row_base;
                     b_col <= b_col + ADDR_ONE;
                     b_ptr <= b_col + ADDR_ONE;
                  end
               end else begin
                  phase <= phase + PH_ONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      prod_ext = ACC_WIDTH'(prod);
      c_value  = acc[DATA_WIDTH-1:0];
      if (SATURATE != 0) begin
         if (acc > SAT_MAX)      c_value = SAT_MAX[DATA_WIDTH-1:0];
         else if (acc < SAT_MIN) c_value = SAT_MIN[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1   <= 1'b0;
         f1   <= 1'b0;
         v2   <= 1'b0;
         f2   <= 1'b0;
         prod <= '0;
         acc  <= '0;
      end else begin
         v1 <= (state == RUN) && (phase < CW'(k_len));
         f1 <= (state == RUN) && (phase == '0);
         v2 <= v1;
         f2 <= f1;
         if (v1) prod <= PW'($signed(rdata_a)) * PW'($signed(rdata_b));
         if (v2) acc <= f2 ? prod_ext : acc + prod_ext;
      end
   end
endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed and randomized jobs on matrix_mac_engine, checked against an arithmetic matrix model.
module tb_matrix_mac_engine;
   localparam int DW  = 32;
   localparam int AW  = 12;
   localparam int DW8 = 8;
   localparam int AW8 = 6;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int a_q[$];
   int b_q[$];

   matrix_mac_engine_if #(.DATA_WIDTH(DW),  .ADDR_WIDTH(AW))  bus   ();
   matrix_mac_engine_if #(.DATA_WIDTH(DW8), .ADDR_WIDTH(AW8)) bus_s ();
   matrix_mac_engine_if #(.DATA_WIDTH(DW8), .ADDR_WIDTH(AW8)) bus_w ();

   matrix_mac_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LEN(100), .MAX_LEN_LOG(7),
                       .ACC_WIDTH(64), .SATURATE(0))
      u_dut (.clk(clk), .reset(reset), .host(bus));
   matrix_mac_engine #(.DATA_WIDTH(DW8), .ADDR_WIDTH(AW8), .MAX_LEN(100), .MAX_LEN_LOG(7),
                       .ACC_WIDTH(16), .SATURATE(1))
      u_sat (.clk(clk), .reset(reset), .host(bus_s));
   matrix_mac_engine #(.DATA_WIDTH(DW8), .ADDR_WIDTH(AW8), .MAX_LEN(100), .MAX_LEN_LOG(7),
                       .ACC_WIDTH(16), .SATURATE(0))
      u_wrap (.clk(clk), .reset(reset), .host(bus_w));

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   task automatic host_write(input int addr, input logic [31:0] d);
      bus.memory_address = AW'(addr);
      bus.memory_data_in = d;
      bus.write_enable   = 1'b1;
      @(negedge clk);
      bus.write_enable   = 1'b0;
   endtask

   task automatic host_read(input int addr, output logic [31:0] d);
      bus.write_enable   = 1'b0;
      bus.memory_address = AW'(addr);
      @(negedge clk);
      d = bus.memory_data_out;
   endtask

   task automatic load_job(input int m, input int k, input int n);
      host_write(0, m);
      host_write(1, k);
      host_write(2, n);
      for (int x = 0; x < m * k; x++) host_write(3 + x, a_q[x]);
      for (int x = 0; x < k * n; x++) host_write(3 + m * k + x, b_q[x]);
   endtask

   task automatic random_operands(input int m, input int k, input int n);
      a_q.delete();
      b_q.delete();
      for (int x = 0; x < m * k; x++) a_q.push_back(int'($urandom()));
      for (int x = 0; x < k * n; x++) b_q.push_back(int'($urandom()));
   endtask

   task automatic run_and_wait(output int cyc);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 20000) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   // Reference: C = A x B with 64-bit wrapping accumulation, low 32 bits kept.
   task automatic verify_c(input int m, input int k, input int n, input string tag);
      logic [31:0] got;
      longint      s;
      for (int i = 0; i < m; i++) begin
         for (int j = 0; j < n; j++) begin
            s = 0;
            for (int kk = 0; kk < k; kk++)
               s += longint'(a_q[i * k + kk]) * longint'(b_q[kk * n + j]);
            host_read(3 + m * k + k * n + i * n + j, got);
            chk($sformatf("%s_c%0d_%0d", tag, i, j), got, 32'(s));
         end
      end
   endtask

   task automatic full_job(input int m, input int k, input int n, input string tag);
      int cyc;
      load_job(m, k, n);
      run_and_wait(cyc);
      chk({tag, "_busy_cycles"}, 32'(cyc), 32'(5 + m * n * (k + 3)));
      chk({tag, "_result_ready"}, 32'(bus.result_ready), 32'd1);
      chk({tag, "_error"}, 32'(bus.error), 32'd0);
      verify_c(m, k, n, tag);
   endtask

   task automatic error_job(input int m, input int k, input int n, input string tag);
      int cyc;
      logic [31:0] got;
      for (int x = 3; x < 15; x++) host_write(x, 32'hC0DE_0000 + 32'(x));
      host_write(0, m);
      host_write(1, k);
      host_write(2, n);
      run_and_wait(cyc);
      chk({tag, "_busy_cycles"}, 32'(cyc), 32'd5);
      chk({tag, "_error"}, 32'(bus.error), 32'd1);
      chk({tag, "_result_ready"}, 32'(bus.result_ready), 32'd0);
      for (int x = 3; x < 15; x++) begin
         host_read(x, got);
         chk($sformatf("%s_ram%0d", tag, x), got, 32'hC0DE_0000 + 32'(x));
      end
   endtask

   task automatic w8(input int addr, input logic [7:0] d);
      bus_s.memory_address = AW8'(addr);
      bus_w.memory_address = AW8'(addr);
      bus_s.memory_data_in = d;
      bus_w.memory_data_in = d;
      bus_s.write_enable   = 1'b1;
      bus_w.write_enable   = 1'b1;
      @(negedge clk);
      bus_s.write_enable   = 1'b0;
      bus_w.write_enable   = 1'b0;
   endtask

   task automatic job8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_sat, input logic [7:0] exp_wrap, input string tag);
      int cyc;
      w8(0, 8'd1);
      w8(1, 8'd1);
      w8(2, 8'd1);
      w8(3, a);
      w8(4, b);
      bus_s.start = 1'b1;
      bus_w.start = 1'b1;
      @(negedge clk);
      bus_s.start = 1'b0;
      bus_w.start = 1'b0;
      cyc = 0;
      while ((bus_s.busy === 1'b1 || bus_w.busy === 1'b1) && cyc < 1000) begin
         cyc++;
         @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, 32'(cyc), 32'd9);
      chk({tag, "_sat_ready"}, 32'(bus_s.result_ready), 32'd1);
      bus_s.memory_address = AW8'(5);
      bus_w.memory_address = AW8'(5);
      @(negedge clk);
      chk({tag, "_sat_c"}, 32'(bus_s.memory_data_out), 32'(exp_sat));
      chk({tag, "_wrap_c"}, 32'(bus_w.memory_data_out), 32'(exp_wrap));
   endtask

   initial begin
      int          cyc;
      logic [31:0] got;

      reset = 1'b0;
      bus.start = 1'b0;   bus.write_enable = 1'b0;   bus.memory_address = '0;   bus.memory_data_in = '0;
      bus_s.start = 1'b0; bus_s.write_enable = 1'b0; bus_s.memory_address = '0; bus_s.memory_data_in = '0;
      bus_w.start = 1'b0; bus_w.write_enable = 1'b0; bus_w.memory_address = '0; bus_w.memory_data_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_result_ready", 32'(bus.result_ready), 32'd0);
      chk("rst_error", 32'(bus.error), 32'd0);
      chk("rst_data_out", bus.memory_data_out, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // 2x2 reference product 19,22,43,50
      a_q = '{1, 2, 3, 4};
      b_q = '{5, 6, 7, 8};
      full_job(2, 2, 2, "t2");
      host_read(11, got);
      chk("t2_c11_const", got, 32'd19);
      host_read(14, got);
      chk("t2_c14_const", got, 32'd50);

      a_q = '{1, -2, 3, -4, 5, -6};
      b_q = '{7, 8, 9};
      full_job(2, 3, 1, "t3");

      error_job(0, 2, 2, "t4_m0");
      error_job(2, 101, 2, "t4_k101");
      error_job(37, 37, 37, "t4_addr_ovf");

      // Host traffic and start pulses during a job are ignored
      random_operands(2, 3, 2);
      load_job(2, 3, 2);
      host_write(20, 32'h5A5A_0020);
      bus.memory_address = AW'(30);
      bus.memory_data_in = 32'h1234_5678;
      bus.write_enable   = 1'b1;
      bus.start          = 1'b1;
      @(negedge clk);
      bus.write_enable = 1'b0;
      bus.start        = 1'b0;
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 1000) begin
         cyc++;
         case (cyc)
            2: begin
               bus.memory_address = AW'(20);
               bus.memory_data_in = 32'hDEAD_BEEF;
               bus.write_enable   = 1'b1;
               bus.start          = 1'b1;
            end
            3: begin
               bus.write_enable = 1'b0;
               bus.start        = 1'b0;
            end
            4: chk("t6_data_out_busy", bus.memory_data_out, 32'd0);
            8: bus.start = 1'b1;
            9: bus.start = 1'b0;
            default: ;
         endcase
         @(negedge clk);
      end
      chk("t6_busy_cycles", 32'(cyc), 32'(5 + 4 * 6));
      chk("t6_result_ready", 32'(bus.result_ready), 32'd1);
      repeat (3) @(negedge clk);
      chk("t6_no_restart_busy", 32'(bus.busy), 32'd0);
      chk("t6_no_restart_ready", 32'(bus.result_ready), 32'd1);
      host_read(20, got);
      chk("t6_addr20_kept", got, 32'h5A5A_0020);
      host_read(30, got);
      chk("t6_start_write", got, 32'h1234_5678);
      verify_c(2, 3, 2, "t6");

      for (int r = 0; r < 4; r++) begin
         int m, k, n;
         m = int'($urandom_range(1, 4));
         k = int'($urandom_range(1, 4));
         n = int'($urandom_range(1, 4));
         random_operands(m, k, n);
         full_job(m, k, n, $sformatf("rnd%0d", r));
      end
      random_operands(1, 1, 1);
      full_job(1, 1, 1, "min_dims");

      // Asynchronous reset in the middle of a 3x3 job
      random_operands(3, 3, 3);
      load_job(3, 3, 3);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (12) @(negedge clk);
      chk("t1_busy_before_reset", 32'(bus.busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("t1_busy_in_reset", 32'(bus.busy), 32'd0);
      chk("t1_ready_in_reset", 32'(bus.result_ready), 32'd0);
      chk("t1_error_in_reset", 32'(bus.error), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_and_wait(cyc);
      chk("t1_busy_cycles", 32'(cyc), 32'(5 + 9 * 6));
      chk("t1_result_ready", 32'(bus.result_ready), 32'd1);
      verify_c(3, 3, 3, "t1");

      // 8-bit instances: 100*100 clamps to 127 or wraps to 16; -100*100 to -128 or -16
      job8(8'd100, 8'd100, 8'h7F, 8'h10, "t5_pos");
      job8(8'h9C, 8'd100, 8'h80, 8'hF0, "t5_neg");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
